btb_assoc_predictor: RTL and testbench

//  N-way set-associative branch target buffer with per-entry saturating direction counters.

---
 rtl/btb_assoc_predictor_pkg.sv | 30 +++
 rtl/btb_assoc_predictor_plru.sv | 39 +++
 rtl/btb_assoc_predictor.sv | 204 ++++++++++++++++++++
 tb/tb_btb_assoc_predictor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/btb_assoc_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btb_assoc_predictor_pkg
// Description : Shared widths, entry types and flush-FSM encodings for the BTB.
// Revision    : 1.0 - initial release
// ============================================================================
package btb_assoc_predictor_pkg;

    localparam int BTB_INDEX_W  = 4;
    localparam int BTB_TAG_W    = 12;
    localparam int BTB_WAYS     = 4;
    localparam int BTB_CTR_W    = 2;
    localparam int BTB_TARGET_W = 16;

    typedef logic [BTB_CTR_W-1:0] btb_ctr_t;

    typedef struct packed {
        logic                    valid;
        logic                    uc;
        btb_ctr_t                ctr;
        logic [BTB_TAG_W-1:0]    tag;
        logic [BTB_TARGET_W-1:0] target;
    } btb_entry_t;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FLUSH = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/btb_assoc_predictor_plru.sv
`default_nettype none
// ============================================================================
// Module      : btb_plru
// Description : Tree pseudo-LRU update and victim selection for one set.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_plru #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         i_bits,
    input  logic [$clog2(WAYS)-1:0] i_touch_way,
    output logic [WAYS-2:0]         o_next_bits,
    output logic [$clog2(WAYS)-1:0] o_victim_way
);

    localparam int c_lvls = $clog2(WAYS);

    // Heap-ordered tree, node n stored at bit n-1; a 1 steers the victim right.
    always_comb begin : touch_walk
        int node;
        o_next_bits = i_bits;
        node        = 1;
        for (int l = c_lvls - 1; l >= 0; l--) begin
            o_next_bits[node-1] = ~i_touch_way[l];
            node                = 2 * node + int'(i_touch_way[l]);
        end
    end

    always_comb begin : victim_walk
        int node;
        node = 1;
        for (int l = 0; l < c_lvls; l++) begin
            node = 2 * node + int'(i_bits[node-1]);
        end
        o_victim_way = c_lvls'(node - WAYS);
    end

endmodule
`default_nettype wire

// File: rtl/btb_assoc_predictor.sv
`default_nettype none
// ============================================================================
// Module      : btb_assoc_predictor
// Description : N-way set-associative BTB with saturating direction counters,
//               tree-PLRU replacement and a sequenced whole-table flush.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_assoc_predictor
    import btb_assoc_predictor_pkg::*;
#(
    parameter int INDEX_W = BTB_INDEX_W,
    parameter int TAG_W   = BTB_TAG_W,
    parameter int WAYS    = BTB_WAYS,
    parameter int CTR_W   = BTB_CTR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INDEX_W-1:0] index_fetch,
    input  logic [TAG_W-1:0]   tag_fetch,
    output logic               hit,
    output logic [15:0]        target,
    output logic               uc_out,
    output logic               pred_taken,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [TAG_W-1:0]   upd_tag,
    input  logic [15:0]        upd_target,
    input  logic               upd_taken,
    input  logic               upd_uc,
    input  logic               flush_req,
    output logic               busy,
    output logic               flush_done
);

    localparam int               c_sets    = 2 ** INDEX_W;
    localparam int               c_way_w   = $clog2(WAYS);
    localparam logic [CTR_W-1:0] c_ctr_max = '1;
    localparam logic [CTR_W-1:0] c_ctr_init = CTR_W'(1) << (CTR_W - 1);
    localparam logic [INDEX_W-1:0] c_last_set = '1;

    logic [WAYS-1:0]    r_valid  [c_sets];
    logic [WAYS-2:0]    r_plru   [c_sets];
    logic [TAG_W-1:0]   r_tag    [c_sets][WAYS];
    logic [15:0]        r_target [c_sets][WAYS];
    logic               r_uc     [c_sets][WAYS];
    logic [CTR_W-1:0]   r_ctr    [c_sets][WAYS];

    logic [1:0]         r_state;
    logic [INDEX_W-1:0] r_ptr;
    logic               r_busy;
    logic               r_flush_done;

    logic [WAYS-1:0]    w_fetch_match;
    logic [c_way_w-1:0] w_fetch_way;
    logic               w_fetch_hit;

    logic [WAYS-1:0]    w_upd_match;
    logic [c_way_w-1:0] w_upd_hit_way;
    logic               w_upd_hit;
    logic               w_free_found;
    logic [c_way_w-1:0] w_free_way;
    logic [c_way_w-1:0] w_plru_victim;
    logic [c_way_w-1:0] w_upd_way;
    logic [WAYS-2:0]    w_plru_next;
    logic [CTR_W-1:0]   w_ctr_cur;
    logic [CTR_W-1:0]   w_ctr_next;
    logic               w_upd_write;
    logic               w_flushing;

    // Tags are unique per set, so OR-ing matching way numbers yields the binary index.
    always_comb begin
        w_fetch_match = '0;
        w_fetch_way   = '0;
        w_upd_match   = '0;
        w_upd_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_fetch_match[w] = r_valid[index_fetch][w] && (r_tag[index_fetch][w] == tag_fetch);
            w_upd_match[w]   = r_valid[upd_index][w] && (r_tag[upd_index][w] == upd_tag);
            if (w_fetch_match[w]) w_fetch_way   = w_fetch_way | c_way_w'(w);
            if (w_upd_match[w])   w_upd_hit_way = w_upd_hit_way | c_way_w'(w);
        end
    end

    assign w_fetch_hit = (|w_fetch_match) & ~r_busy;
    assign hit         = w_fetch_hit;
    assign target      = r_target[index_fetch][w_fetch_way];
    assign uc_out      = w_fetch_hit & r_uc[index_fetch][w_fetch_way];
    assign pred_taken  = w_fetch_hit & (r_uc[index_fetch][w_fetch_way] |
                                        r_ctr[index_fetch][w_fetch_way][CTR_W-1]);

    always_comb begin
        w_free_found = 1'b0;
        w_free_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!r_valid[upd_index][w] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_way   = c_way_w'(w);
            end
        end
    end

    btb_plru #(
        .WAYS (WAYS)
    ) u_plru (
        .i_bits       (r_plru[upd_index]),
        .i_touch_way  (w_upd_way),
        .o_next_bits  (w_plru_next),
        .o_victim_way (w_plru_victim)
    );

    assign w_upd_hit   = |w_upd_match;
    assign w_upd_way   = w_upd_hit    ? w_upd_hit_way :
                         w_free_found ? w_free_way    : w_plru_victim;
    assign w_upd_write = upd_valid & ~r_busy & (w_upd_hit | upd_taken);
    assign w_flushing  = (r_state == c_ST_FLUSH);
    assign w_ctr_cur   = r_ctr[upd_index][w_upd_way];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (upd_taken) begin
            if (w_ctr_cur != c_ctr_max) w_ctr_next = w_ctr_cur + CTR_W'(1);
        end else begin
            if (w_ctr_cur != '0) w_ctr_next = w_ctr_cur - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < c_sets; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else if (w_flushing) begin
            r_valid[r_ptr] <= '0;
            r_plru[r_ptr]  <= '0;
        end else if (w_upd_write) begin
            r_valid[upd_index][w_upd_way] <= 1'b1;
            r_plru[upd_index]             <= w_plru_next;
        end
    end

    // Payload arrays carry no reset; they are only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        if (w_upd_write) begin
            r_uc[upd_index][w_upd_way] <= upd_uc;
            if (upd_taken) r_target[upd_index][w_upd_way] <= upd_target;
            if (w_upd_hit) begin
                r_ctr[upd_index][w_upd_way] <= w_ctr_next;
            end else begin
                r_tag[upd_index][w_upd_way] <= upd_tag;
                r_ctr[upd_index][w_upd_way] <= c_ctr_init;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_ptr        <= '0;
            r_busy       <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_flush_done <= 1'b0;
                    if (flush_req) begin
                        r_state <= c_ST_FLUSH;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_FLUSH: begin
                    if (r_ptr == c_last_set) begin
                        r_state      <= c_ST_DONE;
                        r_busy       <= 1'b0;
                        r_flush_done <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + INDEX_W'(1);
                    end
                end
                c_ST_DONE: begin
                    r_flush_done <= 1'b0;
                    if (flush_req) begin
                        r_state <= c_ST_FLUSH;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= c_ST_IDLE;
                    r_busy       <= 1'b0;
                    r_flush_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign flush_done = r_flush_done;

endmodule
`default_nettype wire

// File: tb/tb_btb_assoc_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_assoc_predictor
// Description : Directed self-checking bench for btb_assoc_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_assoc_predictor;

    logic        clk;
    logic        reset_n;
    logic [3:0]  index_fetch;
    logic [11:0] tag_fetch;
    logic        hit;
    logic [15:0] target;
    logic        uc_out;
    logic        pred_taken;
    logic        upd_valid;
    logic [3:0]  upd_index;
    logic [11:0] upd_tag;
    logic [15:0] upd_target;
    logic        upd_taken;
    logic        upd_uc;
    logic        flush_req;
    logic        busy;
    logic        flush_done;

    int n_tests;
    int n_fail;
    int busy_cycles;
    int done_pulses;

    btb_assoc_predictor dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .index_fetch (index_fetch),
        .tag_fetch   (tag_fetch),
        .hit         (hit),
        .target      (target),
        .uc_out      (uc_out),
        .pred_taken  (pred_taken),
        .upd_valid   (upd_valid),
        .upd_index   (upd_index),
        .upd_tag     (upd_tag),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .upd_uc      (upd_uc),
        .flush_req   (flush_req),
        .busy        (busy),
        .flush_done  (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [3:0] idx, input logic [11:0] tg, input logic [15:0] tgt,
                       input logic taken, input logic uc);
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_index  = idx;
        upd_tag    = tg;
        upd_target = tgt;
        upd_taken  = taken;
        upd_uc     = uc;
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    task automatic look(input logic [3:0] idx, input logic [11:0] tg);
        @(negedge clk);
        index_fetch = idx;
        tag_fetch   = tg;
        #1;
    endtask

    task automatic start_flush();
        @(negedge clk);
        flush_req = 1'b1;
        @(posedge clk);
        #1 flush_req = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        reset_n = 1'b0; index_fetch = '0; tag_fetch = '0;
        upd_valid = 1'b0; upd_index = '0; upd_tag = '0; upd_target = '0;
        upd_taken = 1'b0; upd_uc = 1'b0; flush_req = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        look(4'd3, 12'h0AB);
        check("rst_hit", hit, 0);
        check("rst_pred", pred_taken, 0);
        check("rst_busy", busy, 0);
        check("rst_done", flush_done, 0);

        // Allocate, then walk the counter down and back up
        upd(4'd3, 12'h0AB, 16'h1234, 1'b1, 1'b0);
        look(4'd3, 12'h0AB);
        check("alloc_hit", hit, 1);
        check("alloc_tgt", target, 16'h1234);
        check("alloc_pred", pred_taken, 1);
        check("alloc_uc", uc_out, 0);
        upd(4'd3, 12'h0AB, 16'h9999, 1'b0, 1'b0);
        look(4'd3, 12'h0AB);
        check("nt1_pred", pred_taken, 0);
        check("nt1_tgt", target, 16'h1234);
        upd(4'd3, 12'h0AB, 16'h9999, 1'b0, 1'b0);
        upd(4'd3, 12'h0AB, 16'h9999, 1'b0, 1'b0);
        look(4'd3, 12'h0AB);
        check("nt3_pred", pred_taken, 0);
        upd(4'd3, 12'h0AB, 16'h2222, 1'b1, 1'b0);
        look(4'd3, 12'h0AB);
        check("sat_lo_pred", pred_taken, 0);
        check("tk_tgt", target, 16'h2222);
        upd(4'd3, 12'h0AB, 16'h2222, 1'b1, 1'b0);
        look(4'd3, 12'h0AB);
        check("tk2_pred", pred_taken, 1);

        // Not-taken miss leaves the table untouched
        upd(4'd6, 12'h077, 16'h0600, 1'b0, 1'b0);
        look(4'd6, 12'h077);
        check("ntmiss_hit", hit, 0);

        // PLRU replacement in set 5
        for (int t = 1; t <= 4; t++) upd(4'd5, 12'(t), 16'h0500 + 16'(t), 1'b1, 1'b0);
        upd(4'd5, 12'd1, 16'h0501, 1'b1, 1'b0);
        upd(4'd5, 12'd3, 16'h0503, 1'b1, 1'b0);
        upd(4'd5, 12'd2, 16'h0502, 1'b1, 1'b0);
        upd(4'd5, 12'd5, 16'h0505, 1'b1, 1'b0);
        look(4'd5, 12'd4);
        check("plru_evict4", hit, 0);
        for (int t = 1; t <= 5; t++) begin
            if (t != 4) begin
                look(4'd5, 12'(t));
                check("plru_keep", hit, 1);
                check("plru_tgt", target, 16'h0500 + 16'(t));
            end
        end

        // Unconditional entry predicts taken regardless of the counter
        upd(4'd7, 12'h03C, 16'h4000, 1'b1, 1'b1);
        upd(4'd7, 12'h03C, 16'h4000, 1'b0, 1'b1);
        upd(4'd7, 12'h03C, 16'h4000, 1'b0, 1'b1);
        look(4'd7, 12'h03C);
        check("uc_hit", hit, 1);
        check("uc_out", uc_out, 1);
        check("uc_pred", pred_taken, 1);

        // Flush: 16 busy cycles, hits masked, update and re-request ignored
        upd(4'd15, 12'hF0F, 16'hF000, 1'b1, 1'b0);
        look(4'd15, 12'hF0F);
        check("pre_flush_hit", hit, 1);
        start_flush();
        check("flush_busy", busy, 1);
        busy_cycles = 0;
        done_pulses = 0;
        for (int c = 0; c < 24; c++) begin
            if (busy) begin
                busy_cycles++;
                check("flush_hit_mask", hit, 0);
            end
            if (flush_done) begin
                done_pulses++;
                check("done_busy", busy, 0);
            end
            if (c == 5) begin
                upd_valid = 1'b1; upd_index = 4'd1; upd_tag = 12'h099;
                upd_target = 16'h0990; upd_taken = 1'b1; upd_uc = 1'b0;
            end else if (c == 8) begin
                flush_req = 1'b1;
            end else begin
                upd_valid = 1'b0;
                flush_req = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check("flush_cycles", busy_cycles, 16);
        check("flush_pulses", done_pulses, 1);
        look(4'd1, 12'h099);
        check("flush_upd_drop", hit, 0);
        look(4'd3, 12'h0AB);
        check("post_flush3", hit, 0);
        look(4'd5, 12'd1);
        check("post_flush5", hit, 0);
        look(4'd7, 12'h03C);
        check("post_flush7", hit, 0);
        look(4'd15, 12'hF0F);
        check("post_flush15", hit, 0);

        // Reset during a flush
        upd(4'd3, 12'h0AB, 16'h1234, 1'b1, 1'b0);
        upd(4'd15, 12'hF0F, 16'hF000, 1'b1, 1'b0);
        look(4'd3, 12'h0AB);
        check("refill_hit", hit, 1);
        start_flush();
        repeat (7) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_done", flush_done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        busy_cycles = 0;
        done_pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
            if (flush_done) done_pulses++;
        end
        check("rstmid_no_busy", busy_cycles, 0);
        check("rstmid_no_pulse", done_pulses, 0);
        look(4'd3, 12'h0AB);
        check("rstmid_miss3", hit, 0);
        look(4'd15, 12'hF0F);
        check("rstmid_miss15", hit, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
